lif_tdm_scheduler: RTL and testbench

//   Time-multiplexes one LIF update datapath across N_NEURON neurons of a layer.

---
 rtl/lif_tdm_if.sv | 22 ++
 rtl/lif_tdm_scheduler.sv | 145 ++++++++++++++
 tb/tb_lif_tdm_scheduler.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/lif_tdm_if.sv
// Handshake bundle for lif_tdm_scheduler: packed input-current vector in, spike vector out.
interface lif_tdm_if #(
  parameter int N_NEURON = 8,
  parameter int V_SIZE   = 8
);
  logic                       in_valid;
  logic                       in_ready;
  logic [N_NEURON*V_SIZE-1:0] in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [N_NEURON-1:0]        out_spikes;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_spikes
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_spikes
  );
endinterface

// File: rtl/lif_tdm_scheduler.sv
// Time-multiplexed LIF layer: one shared update datapath walks all neurons of a timestep,
// a read stage (p0, cur_idx) followed by a compute/write-back stage (p1).
module lif_tdm_scheduler #(
  parameter int N_NEURON  = 8,
  parameter int V_SIZE    = 8,
  parameter int THRESHOLD = 100,
  parameter int V_LEAK    = 1,
  parameter int IDX_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  lif_tdm_if.slave         bus,
  output logic             busy,
  output logic [IDX_W-1:0] cur_idx
);

  localparam logic [V_SIZE-2:0] THR  = (V_SIZE-1)'(THRESHOLD);
  localparam logic [V_SIZE-1:0] LEAK = V_SIZE'(V_LEAK);
  localparam logic [IDX_W-1:0]  LAST = IDX_W'(N_NEURON-1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       iss_q, iss_d;
  logic                       accept;

  logic [N_NEURON*V_SIZE-1:0] x_q;
  logic                       vld_p1_q;
  logic [IDX_W-1:0]           idx_p1_q;
  logic signed [V_SIZE-1:0]   x_p1_q;
  logic [V_SIZE-2:0]          v_p1_q;
  logic [V_SIZE-2:0]          u_p1;
  logic                       fire_p1;

  logic [V_SIZE-2:0]          v_q [N_NEURON];
  logic [N_NEURON-1:0]        acc_q, acc_d;
  logic [N_NEURON-1:0]        spk_q;

  // Integrate, leak, then clamp: overflow saturates (leak skipped), negative results floor at 0.
  function automatic logic [V_SIZE-2:0] lif_update(input logic signed [V_SIZE-1:0] x,
                                                   input logic [V_SIZE-2:0]        v);
    logic signed [V_SIZE-1:0] p;
    logic signed [V_SIZE-1:0] s;
    logic [V_SIZE-2:0]        u;
    p = $signed({1'b0, v}) + x;
    s = p - $signed(LEAK);
    if (!x[V_SIZE-1] && p[V_SIZE-1]) begin
      u = '1;
    end else if (p[V_SIZE-1] || s[V_SIZE-1]) begin
      u = '0;
    end else begin
      u = s[V_SIZE-2:0];
    end
    return u;
  endfunction

  assign accept         = (state_q == IDLE) && bus.in_valid;
  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.out_spikes = spk_q;
  assign busy           = (state_q != IDLE);
  assign cur_idx        = (state_q == RUN && iss_q) ? idx_q : '0;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    iss_d   = iss_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = RUN;
          idx_d   = '0;
          iss_d   = 1'b1;
        end
      end
      RUN: begin
        if (iss_q) begin
          if (idx_q == LAST) begin
            iss_d = 1'b0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          // Drain cycle: the last neuron is written back as we enter DONE.
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // p1: compute the update for the neuron read in p0
  assign u_p1    = lif_update(x_p1_q, v_p1_q);
  assign fire_p1 = (u_p1 >= THR);

  always_comb begin
    acc_d = acc_q;
    if (vld_p1_q) begin
      acc_d[idx_p1_q] = fire_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      iss_q    <= 1'b0;
      vld_p1_q <= 1'b0;
      acc_q    <= '0;
      spk_q    <= '0;
      for (int i = 0; i < N_NEURON; i++) begin
        v_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      iss_q    <= iss_d;
      vld_p1_q <= (state_q == RUN) && iss_q;
      acc_q    <= accept ? '0 : acc_d;
      if (state_q == RUN && !iss_q) begin
        spk_q <= acc_d;
      end
      if (vld_p1_q) begin
        v_q[idx_p1_q] <= fire_p1 ? '0 : u_p1;
      end
    end
  end

  // p0: latch the vector on accept, then read one neuron's input and voltage per cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      x_q <= bus.in_data;
    end
    x_p1_q   <= $signed(x_q[int'(idx_q)*V_SIZE +: V_SIZE]);
    v_p1_q   <= v_q[idx_q];
    idx_p1_q <= idx_q;
  end

endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// Directed and randomized bench for lif_tdm_scheduler against an integer LIF reference model.
module tb_lif_tdm_scheduler;
  localparam int N    = 8;
  localparam int V    = 8;
  localparam int THR  = 100;
  localparam int LEAK = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [2:0] cur_idx;

  lif_tdm_if #(.N_NEURON(N), .V_SIZE(V)) bus ();

  lif_tdm_scheduler #(
    .N_NEURON(N), .V_SIZE(V), .THRESHOLD(THR), .V_LEAK(LEAK), .IDX_W(3)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .busy(busy), .cur_idx(cur_idx)
  );

  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_err = 0;
  int           mv[N];
  logic [N-1:0] exp_spk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [N*V-1:0] mkvec(input int idx, input int val);
    logic [N*V-1:0] r;
    r = '0;
    r[idx*V +: V] = V'(val);
    return r;
  endfunction

  task automatic model_step(input logic [N*V-1:0] vec);
    for (int i = 0; i < N; i++) begin
      logic signed [V-1:0] xs;
      int p;
      int u;
      xs = vec[i*V +: V];
      p  = mv[i] + int'(xs);
      if (p > 127)          u = 127;
      else if (p - LEAK < 0) u = 0;
      else                   u = p - LEAK;
      exp_spk[i] = (u >= THR);
      mv[i]      = (u >= THR) ? 0 : u;
    end
  endtask

  task automatic present(input logic [N*V-1:0] vec, input string tag);
    int w;
    w = 0;
    @(negedge clk);
    bus.in_data  = vec;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_accept_wait"}, 64'(w < 50), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = {$urandom, $urandom};
    model_step(vec);
  endtask

  // Called #1 after the accept edge.
  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    chk({tag, "_busy"}, 64'(busy), 1);
    chk({tag, "_in_ready_run"}, 64'(bus.in_ready), 0);
    chk({tag, "_cur_idx0"}, 64'(cur_idx), 0);
    while (!bus.out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 3) chk({tag, "_cur_idx3"}, 64'(cur_idx), 3);
    end
    chk({tag, "_latency"}, 64'(cyc), N + 1);
    chk({tag, "_spikes"}, 64'(bus.out_spikes), 64'(exp_spk));
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_v%0d", tag, i), 64'(dut.v_q[i]), 64'(mv[i]));
    end
  endtask

  task automatic release_out(input int hold, input string tag);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    chk({tag, "_valid_held"}, 64'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 64'(bus.out_valid), 0);
    chk({tag, "_idle_ready"}, 64'(bus.in_ready), 1);
    chk({tag, "_spk_hold"}, 64'(bus.out_spikes), 64'(exp_spk));
  endtask

  initial begin
    logic [N*V-1:0] vec;
    int             seen;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < N; i++) mv[i] = 0;
    exp_spk = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 1);
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_cur_idx", 64'(cur_idx), 0);
    chk("rst_spikes", 64'(bus.out_spikes), 0);
    for (int i = 0; i < N; i++) chk($sformatf("rst_v%0d", i), 64'(dut.v_q[i]), 0);
    rst = 1'b0;

    // All-zero timestep
    present('0, "t1");
    wait_done("t1");
    chk("t1_spk_const", 64'(bus.out_spikes), 0);
    release_out(0, "t1");

    // Neuron 3 integrates +51 twice
    present(mkvec(3, 51), "t2a");
    wait_done("t2a");
    chk("t2a_v3_const", 64'(dut.v_q[3]), 50);
    chk("t2a_spk_const", 64'(bus.out_spikes), 0);
    release_out(0, "t2a");
    present(mkvec(3, 51), "t2b");
    wait_done("t2b");
    chk("t2b_spk_const", 64'(bus.out_spikes), 8'h08);
    chk("t2b_v3_const", 64'(dut.v_q[3]), 0);
    release_out(1, "t2b");

    // Saturation, floor and just-below-threshold
    present(mkvec(2, 100), "t3a");
    wait_done("t3a");
    chk("t3a_v2_const", 64'(dut.v_q[2]), 99);
    chk("t3a_spk_const", 64'(bus.out_spikes), 0);
    release_out(0, "t3a");
    present(mkvec(0, 127) | mkvec(1, -128) | mkvec(2, 100), "t3b");
    wait_done("t3b");
    chk("t3b_spk_const", 64'(bus.out_spikes), 8'h05);
    chk("t3b_v1_const", 64'(dut.v_q[1]), 0);
    chk("t3b_v2_const", 64'(dut.v_q[2]), 0);
    release_out(0, "t3b");

    // Backpressure in DONE with a waiting vector
    present('0, "t4a");
    wait_done("t4a");
    @(negedge clk);
    bus.in_data  = mkvec(5, 120);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("t4_in_ready_%0d", k), 64'(bus.in_ready), 0);
      chk($sformatf("t4_out_valid_%0d", k), 64'(bus.out_valid), 1);
      chk($sformatf("t4_spk_%0d", k), 64'(bus.out_spikes), 0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("t4_hs_in_ready", 64'(bus.in_ready), 1);
    chk("t4_hs_out_valid", 64'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("t4_next_accepted", 64'(bus.in_ready), 0);
    model_step(mkvec(5, 120));
    wait_done("t4b");
    chk("t4b_spk_const", 64'(bus.out_spikes), 8'h20);
    release_out(0, "t4b");

    // Reset during RUN cycle 4
    vec = '0;
    for (int i = 0; i < N; i++) vec[i*V +: V] = 8'd30;
    present(vec, "t5");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) mv[i] = 0;
    chk("t5_busy", 64'(busy), 0);
    chk("t5_in_ready", 64'(bus.in_ready), 1);
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1;
    end
    chk("t5_no_out_valid", 64'(seen), 0);
    present('0, "t5z");
    wait_done("t5z");
    release_out(0, "t5z");

    // Random timesteps
    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < N; i++) vec[i*V +: V] = V'($urandom_range(0, 255));
      present(vec, "rnd");
      wait_done($sformatf("rnd%0d", n));
      release_out(int'($urandom_range(0, 2)), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
